cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the five-stage MIPS pipeline; sits beside the M stage.
- Collects the M-stage exception code, including the AdEL/AdES result of the memory-address check, and the timer/external hardware interrupt lines.
- Decides whether to enter the handler and records SR/Cause/EPC state.
- Drives the flush/redirect request consumed by the hazard unit and PC mux; serves mfc0/mtc0/eret.

Parameters:
- PRID, 32'h0000_2019: read-only PRId (reg 15) value.
- HANDLER_ADDR, 32'h0000_4180: exception entry PC driven on ExcPC.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- A1  in  5  mfc0 read select (rd field).
- A2  in  5  mtc0 write select.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- PC  in  32  PC of the instruction currently in M (word aligned).
- BD_in  in  1  M instruction is in a branch delay slot.
- ExcCode_in  in  5  [6:2] M-stage exception code; 0 = none, 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- HWInt  in  6  [7:2] interrupt lines; [2] timer0, [3] timer1, [4] external, others tied 0.
- EXLClr  in  1  eret in M.
- IntReq  out  1  take exception/interrupt this cycle (flush F..M, redirect PC).
- ExcPC  out  32  HANDLER_ADDR.
- EPC  out  32  current EPC register, used by eret redirect.
- DOut  out  32  mfc0 read data.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - EPC (14): 32-bit.
  - PRId (15): constant PRID.
- Reset (async, immediate): SR=0, Cause=0, EPC=0. Outputs: IntReq=0, DOut=0 for A1=12..14, EPC=0.
- Combinational decisions:
  - int_pend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
  - exc_pend = (ExcCode_in != 0) & ~SR.EXL.
  - IntReq = int_pend | exc_pend, same cycle, zero latency.
- Priority: interrupt beats a synchronous exception in the same cycle; the exception re-raises after eret because the instruction re-executes.
- Cause.IP: sampled from HWInt on every rising edge unconditionally, including while EXL=1. Not software-writable.
- On a rising edge with IntReq=1:
  - SR.EXL<=1.
  - Cause.ExcCode <= int_pend ? 0 : ExcCode_in.
  - Cause.BD <= BD_in.
  - EPC <= BD_in ? PC-4 : PC, with bits [1:0] forced 0.
- EXLClr=1 and IntReq=0: SR.EXL<=0 on the edge. All other state is unchanged.
- EXLClr=1 and IntReq=1 in the same cycle cannot occur legally, because eret in M masks exc via EXL. If it does occur, IntReq wins: EXL stays 1 and the entry is recorded.
- mtc0 (WE=1, IntReq=0):
  - A2=12: SR <= DIn masked to IM/EXL/IE.
  - A2=14: EPC <= {DIn[31:2],2'b00}.
  - A2=13 and A2=15: ignored.
  - Any other A2: ignored.
- mtc0 with IntReq=1: the write is dropped, because the instruction is flushed.
- mfc0: DOut is a combinational read of the current register value; pre-edge value, no bypass of a same-cycle write. Unmapped A1 returns 0.
- Nested entry is impossible while EXL=1: both int_pend and exc_pend are masked, so EPC is preserved.
- ExcPC is constant HANDLER_ADDR.

Test Plan:
- Reset mid-run: set SR=32'h0000_fc01 via mtc0, assert reset for 1 ns off-edge -> SR/Cause/EPC read 0 immediately, IntReq=0.
- AdEL entry: EXL=0, ExcCode_in=4, PC=32'h0000_3010, BD_in=0 -> IntReq=1 same cycle. After the edge: Cause=32'h0000_0010, EPC=32'h0000_3010, SR.EXL=1, IntReq=0 even with ExcCode_in still 4.
- Delay-slot AdES: ExcCode_in=5, PC=32'h0000_3024, BD_in=1 -> EPC=32'h0000_3020, Cause=32'h8000_0014.
- Timer interrupt:
  - SR=32'h0000_0401, HWInt=6'b000001 -> IntReq=1; after the edge ExcCode=0, Cause.IP[10]=1.
  - Same setup with IE=0 or IM[10]=0 -> IntReq=0, but Cause.IP[10] still reads 1.
- Simultaneous: SR=32'h0000_0401, HWInt[2]=1, ExcCode_in=12 -> Cause.ExcCode=0 (interrupt wins). Also assert WE=1, A2=14 in the same cycle -> EPC=PC, write dropped.
- eret/mtc0:
  - EXLClr=1 -> EXL cleared next edge, EPC unchanged.
  - mtc0 A2=14 DIn=32'h0000_3007 -> EPC reads 32'h0000_3004.
  - mtc0 A2=13 -> Cause unchanged.
  - mfc0 A1=15 -> PRID.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the M stage.
// Holds SR/Cause/EPC/PRId, raises IntReq and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
   parameter logic [31:0] PRID         = 32'h0000_2019,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] PC,
   input  logic        BD_in,
   input  logic [6:2]  ExcCode_in,
   input  logic [7:2]  HWInt,
   input  logic        EXLClr,
   output logic        IntReq,
   output logic [31:0] ExcPC,
   output logic [31:0] EPC,
   output logic [31:0] DOut
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_q, exc_d;
   logic [31:0] epc_q, epc_d;

   logic        int_pend;
   logic        exc_pend;
   logic [31:0] epc_entry;
   logic [31:0] sr_val;
   logic [31:0] cause_val;

   assign int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
   assign exc_pend = (ExcCode_in != 5'd0) & ~exl_q;
   assign IntReq   = int_pend | exc_pend;
   assign ExcPC    = HANDLER_ADDR;
   assign EPC      = epc_q;

   // A delay-slot instruction restarts at its branch.
   assign epc_entry = BD_in ? (PC - 32'd4) : PC;

   assign sr_val    = {16'h0, im_q, 8'h0, exl_q, ie_q};
   assign cause_val = {bd_q, 15'h0, ip_q, 3'h0, exc_q, 2'h0};

   always_comb begin
      im_d  = im_q;
      exl_d = exl_q;
      ie_d  = ie_q;
      bd_d  = bd_q;
      ip_d  = HWInt;
      exc_d = exc_q;
      epc_d = epc_q;
      if (IntReq) begin
         exl_d = 1'b1;
         exc_d = int_pend ? 5'd0 : ExcCode_in;
         bd_d  = BD_in;
         epc_d = {epc_entry[31:2], 2'b00};
      end else begin
         if (EXLClr) begin
            exl_d = 1'b0;
         end
         if (WE) begin
            unique case (A2)
               5'd12: begin
                  im_d  = DIn[15:10];
                  exl_d = DIn[1];
                  ie_d  = DIn[0];
               end
               5'd14: epc_d = {DIn[31:2], 2'b00};
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_q  <= 6'd0;
         exl_q <= 1'b0;
         ie_q  <= 1'b0;
         bd_q  <= 1'b0;
         ip_q  <= 6'd0;
         exc_q <= 5'd0;
         epc_q <= 32'd0;
      end else begin
         im_q  <= im_d;
         exl_q <= exl_d;
         ie_q  <= ie_d;
         bd_q  <= bd_d;
         ip_q  <= ip_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   always_comb begin
      DOut = 32'd0;
      unique case (A1)
         5'd12: DOut = sr_val;
         5'd13: DOut = cause_val;
         5'd14: DOut = epc_q;
         5'd15: DOut = PRID;
         default: DOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed-vector bench for cp0_exc_ctrl.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] PC;
   logic        BD_in;
   logic [6:2]  ExcCode_in;
   logic [7:2]  HWInt;
   logic        EXLClr;
   logic        IntReq;
   logic [31:0] ExcPC, EPC, DOut;

   int vecs = 0;
   int errs = 0;

   cp0_exc_ctrl dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn),
      .WE(WE), .PC(PC), .BD_in(BD_in), .ExcCode_in(ExcCode_in),
      .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq),
      .ExcPC(ExcPC), .EPC(EPC), .DOut(DOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a,
                     input logic [31:0] exp);
      A1 = a;
      #1;
      chk(tag, DOut, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      WE = 1'b1; A2 = a; DIn = d;
      tick();
      WE = 1'b0; A2 = 5'd0; DIn = 32'd0;
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
      PC = 32'h0000_3000; BD_in = 1'b0; ExcCode_in = 5'd0;
      HWInt = 6'd0; EXLClr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_intreq", {31'd0, IntReq}, 32'd0);
      chk("rst_epc", EPC, 32'd0);
      chk("excpc", ExcPC, 32'h0000_4180);
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);

      // mid-run asynchronous reset
      mtc0(5'd12, 32'h0000_fc01);
      mtc0(5'd14, 32'h0000_3abc);
      rd("sr_wr", 5'd12, 32'h0000_fc01);
      rd("epc_wr", 5'd14, 32'h0000_3abc);
      reset = 1'b1;
      #1;
      chk("arst_intreq", {31'd0, IntReq}, 32'd0);
      rd("arst_sr", 5'd12, 32'd0);
      rd("arst_cause", 5'd13, 32'd0);
      rd("arst_epc", 5'd14, 32'd0);
      reset = 1'b0;
      tick();

      // AdEL entry
      ExcCode_in = 5'd4; PC = 32'h0000_3010; BD_in = 1'b0;
      #1;
      chk("adel_req", {31'd0, IntReq}, 32'd1);
      tick();
      rd("adel_cause", 5'd13, 32'h0000_0010);
      rd("adel_epc", 5'd14, 32'h0000_3010);
      rd("adel_sr", 5'd12, 32'h0000_0002);
      chk("adel_masked", {31'd0, IntReq}, 32'd0);

      // eret clears EXL only
      ExcCode_in = 5'd0; EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      rd("eret_sr", 5'd12, 32'd0);
      rd("eret_epc", 5'd14, 32'h0000_3010);

      // AdES in a delay slot
      ExcCode_in = 5'd5; PC = 32'h0000_3024; BD_in = 1'b1;
      #1;
      chk("ades_req", {31'd0, IntReq}, 32'd1);
      tick();
      ExcCode_in = 5'd0; BD_in = 1'b0;
      rd("ades_epc", 5'd14, 32'h0000_3020);
      rd("ades_cause", 5'd13, 32'h8000_0014);
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;

      // timer interrupt
      mtc0(5'd12, 32'h0000_0401);
      PC = 32'h0000_3100; HWInt = 6'b000001;
      #1;
      chk("tmr_req", {31'd0, IntReq}, 32'd1);
      tick();
      rd("tmr_cause", 5'd13, 32'h0000_0400);
      rd("tmr_sr", 5'd12, 32'h0000_0403);
      rd("tmr_epc", 5'd14, 32'h0000_3100);

      // IE=0 and IM[10]=0 mask the line but IP still samples it
      mtc0(5'd12, 32'h0000_0400);
      chk("ie0_req", {31'd0, IntReq}, 32'd0);
      rd("ie0_ip", 5'd13, 32'h0000_0400);
      mtc0(5'd12, 32'h0000_0001);
      chk("im0_req", {31'd0, IntReq}, 32'd0);
      rd("im0_ip", 5'd13, 32'h0000_0400);

      // interrupt beats Ov, same-cycle mtc0 EPC dropped
      mtc0(5'd12, 32'h0000_0401);
      ExcCode_in = 5'd12; PC = 32'h0000_3200;
      WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5554;
      #1;
      chk("sim_req", {31'd0, IntReq}, 32'd1);
      tick();
      WE = 1'b0; A2 = 5'd0; DIn = 32'd0;
      ExcCode_in = 5'd0; HWInt = 6'd0;
      rd("sim_cause", 5'd13, 32'h0000_0400);
      rd("sim_epc", 5'd14, 32'h0000_3200);
      chk("sim_epc_port", EPC, 32'h0000_3200);
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
      rd("eret2_sr", 5'd12, 32'h0000_0401);
      rd("eret2_epc", 5'd14, 32'h0000_3200);

      // mtc0 EPC alignment, Cause write ignored
      mtc0(5'd14, 32'h0000_3007);
      rd("mtc0_epc", 5'd14, 32'h0000_3004);
      chk("mtc0_epc_port", EPC, 32'h0000_3004);
      mtc0(5'd13, 32'hffff_ffff);
      rd("mtc0_cause", 5'd13, 32'd0);

      rd("prid", 5'd15, 32'h0000_2019);
      rd("unmapped", 5'd3, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
